// File: rtl/eth_rx_uart_bridge.sv
// eth_rx_uart_bridge: buffers received bytes in a FIFO and serialises them
// as UART characters (configurable baud divisor, frame format and depth).
// Single clock domain (phy_rx_clk), asynchronous active-high reset.
module eth_rx_uart_bridge #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          phy_rx_clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          tx_en,
  output logic          uart_txd,
  output logic          tx_busy,
  output logic [LW-1:0] fifo_level,
  output logic          fifo_full,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);
  localparam logic          PAR_ODD    = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Transmitter state
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   busy_q, busy_d;

  // FIFO state
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            drop_q, drop_d;

  logic                   full;
  logic                   bit_done;
  logic                   stop_last;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [7:0]             rd_data;
  logic                   unused_rd_data;

  assign rd_data   = mem_q[rd_ptr_q];
  assign full      = (level_q == LEVEL_FULL);
  assign bit_done  = (cnt_q == CNT_LAST);
  assign stop_last = (state_q == S_STOP) && bit_done && (bit_q == STOP_LAST);
  // A pop happens from IDLE or in the final stop cycle so characters can run back to back.
  assign pop       = ((state_q == S_IDLE) || stop_last) && tx_en && (level_q != '0);
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  // Bits of the stored byte above DATA_BITS are never transmitted.
  assign unused_rd_data = ^rd_data;

  // FIFO storage: written on accepted pushes only, no reset needed
  always_ff @(posedge phy_rx_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers, level and drop accounting: next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = drop;
    drop_d     = drop_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // FIFO pointers, level and drop accounting: registers
  always_ff @(posedge phy_rx_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Transmit FSM: next state, bit timing, shift register and registered line value
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_done ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = '0;
      shreg_d = rd_data[DATA_BITS-1:0];
      par_d   = (^rd_data[DATA_BITS-1:0]) ^ PAR_ODD;
    end

    // The line value is computed from the next state so uart_txd comes straight from a flop.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shreg_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Transmit FSM: registers
  always_ff @(posedge phy_rx_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign uart_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign fifo_level = level_q;
  assign fifo_full  = full;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_q;

endmodule
